// File: rtl/controller_event_gen_pkg.sv
// Shared definitions for the gamepad poll scheduler and event generator.
// Button bit positions, poll FSM encoding and mask helpers.
package controller_event_gen_pkg;

  localparam int BTN_START = 0;
  localparam int BTN_Z     = 1;
  localparam int BTN_Y     = 2;
  localparam int BTN_X     = 3;
  localparam int BTN_C     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_RIGHT = 7;
  localparam int BTN_LEFT  = 8;
  localparam int BTN_DOWN  = 9;
  localparam int BTN_UP    = 10;
  localparam int BTN_COUNT = 11;

  localparam int DIR_LO    = BTN_RIGHT;
  localparam int DIR_COUNT = BTN_UP - BTN_RIGHT + 1;

  typedef logic [BTN_COUNT-1:0] btn_mask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT,
    ST_SAMPLE,
    ST_UPDATE,
    ST_GAP
  } poll_state_t;

  function automatic logic [3:0] top_index(
    input btn_mask_t m
  );
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < BTN_COUNT; i++) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic btn_mask_t onehot(
    input logic [3:0] idx
  );
    return btn_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/controller_event_arbiter.sv
// Pending-event mask with fixed priority selection (up highest, start lowest).
// Presents one event at a time and retires it on acknowledge.
module controller_event_arbiter
  import controller_event_gen_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  btn_mask_t  set_mask,
  input  logic       event_ack,
  output logic       event_valid,
  output logic [3:0] event_code
);

  btn_mask_t pending;
  btn_mask_t clr_mask;
  logic      take;

  assign take     = event_valid & event_ack;
  assign clr_mask = take ? onehot(event_code) : '0;

  // A set arriving with the ack of the same bit keeps it pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      event_valid <= 1'b0;
      event_code  <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (take) begin
        event_valid <= 1'b0;
      end else if (!event_valid && |pending) begin
        event_valid <= 1'b1;
        event_code  <= top_index(pending);
      end
    end
  end

endmodule

// File: rtl/controller_event_gen.sv
// Poll scheduler, debouncer and auto-repeat for the 6-button pad scanner.
// Feeds press/repeat strobes into the event arbiter.
module controller_event_gen
  import controller_event_gen_pkg::*;
#(
  parameter int POLL_PERIOD    = 1000000,
  parameter int PULSE_CYCLES   = 4,
  parameter int SCAN_WAIT      = 8100,
  parameter int DEBOUNCE_POLLS = 2,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_RATE    = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] buttons_in,
  output logic        poll_req,
  output logic [11:0] buttons_stable,
  output logic        event_valid,
  output logic [3:0]  event_code,
  input  logic        event_ack
);

  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int CMAX = (SCAN_WAIT > PULSE_CYCLES) ?
                        SCAN_WAIT : PULSE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  if (POLL_PERIOD < PULSE_CYCLES + SCAN_WAIT + 3) begin : g_bad_period
    $fatal(1, "POLL_PERIOD too short for pulse, wait, sample, update");
  end
  if (DEBOUNCE_POLLS < 1 || DEBOUNCE_POLLS > 15) begin : g_bad_db
    $fatal(1, "DEBOUNCE_POLLS must be 1..15");
  end
  if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY ||
      REPEAT_DELAY > 255) begin : g_bad_rep
    $fatal(1, "need 1 <= REPEAT_RATE <= REPEAT_DELAY <= 255");
  end

  poll_state_t state;
  logic [PW-1:0] period_cnt;
  logic [CW-1:0] phase_cnt;

  btn_mask_t sample_q;
  btn_mask_t prev_q;
  btn_mask_t stable_q;
  logic [3:0] match_cnt;
  logic [7:0] held_cnt [DIR_COUNT];

  logic [3:0] match_next;
  btn_mask_t  stable_next;
  btn_mask_t  press;
  btn_mask_t  fire;
  btn_mask_t  set_mask;
  logic [7:0] held_next [DIR_COUNT];
  logic       unused_bit;

  assign unused_bit     = buttons_in[11];
  assign buttons_stable = {1'b0, stable_q};

  // Everything below is only consumed during the UPDATE cycle.
  always_comb begin
    if (sample_q == prev_q) begin
      match_next = (match_cnt == 4'd15) ?
                   4'd15 : match_cnt + 4'd1;
    end else begin
      match_next = 4'd1;
    end
    stable_next = (match_next >= 4'(DEBOUNCE_POLLS)) ?
                  sample_q : stable_q;
    press = (stable_next != stable_q) ?
            (sample_q & ~stable_q) : '0;
    fire = '0;
    for (int d = 0; d < DIR_COUNT; d++) begin
      held_next[d] = held_cnt[d] + 8'd1;
      if (!stable_next[DIR_LO+d] || press[DIR_LO+d]) begin
        held_next[d] = '0;
      end else if (held_next[d] == 8'(REPEAT_DELAY)) begin
        fire[DIR_LO+d] = 1'b1;
        held_next[d]   = 8'(REPEAT_DELAY - REPEAT_RATE);
      end
    end
    set_mask = (state == ST_UPDATE) ? (press | fire) : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      period_cnt <= '0;
      phase_cnt  <= '0;
      poll_req   <= 1'b0;
      sample_q   <= '0;
      prev_q     <= '0;
      stable_q   <= '0;
      match_cnt  <= '0;
      for (int d = 0; d < DIR_COUNT; d++) begin
        held_cnt[d] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          period_cnt <= '0;
          phase_cnt  <= '0;
          if (enable) begin
            state    <= ST_PULSE;
            poll_req <= 1'b1;
          end
        end
        ST_PULSE: begin
          period_cnt <= period_cnt + PW'(1);
          if (phase_cnt == CW'(PULSE_CYCLES - 1)) begin
            state     <= ST_WAIT;
            poll_req  <= 1'b0;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          period_cnt <= period_cnt + PW'(1);
          if (phase_cnt == CW'(SCAN_WAIT - 1)) begin
            state <= ST_SAMPLE;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        ST_SAMPLE: begin
          period_cnt <= period_cnt + PW'(1);
          sample_q   <= buttons_in[BTN_COUNT-1:0];
          state      <= ST_UPDATE;
        end
        ST_UPDATE: begin
          period_cnt <= period_cnt + PW'(1);
          prev_q     <= sample_q;
          match_cnt  <= match_next;
          stable_q   <= stable_next;
          for (int d = 0; d < DIR_COUNT; d++) begin
            held_cnt[d] <= held_next[d];
          end
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (period_cnt == PW'(POLL_PERIOD - 1)) begin
            period_cnt <= '0;
            phase_cnt  <= '0;
            if (enable) begin
              state    <= ST_PULSE;
              poll_req <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            period_cnt <= period_cnt + PW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  controller_event_arbiter u_arb (
    .clock       (clock),
    .reset       (reset),
    .set_mask    (set_mask),
    .event_ack   (event_ack),
    .event_valid (event_valid),
    .event_code  (event_code)
  );

endmodule

// File: tb/tb_controller_event_gen.sv
// Bench for controller_event_gen: directed scenarios plus random polls
// against a per-poll model of debounce, repeat and event ordering.
module tb_controller_event_gen;

  localparam int PP = 100;
  localparam int PC = 2;
  localparam int SW = 20;
  localparam int DB = 2;
  localparam int RD = 3;
  localparam int RR = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        event_ack = 1'b0;
  logic [11:0] buttons_in = '0;
  logic        poll_req;
  logic [11:0] buttons_stable;
  logic        event_valid;
  logic [3:0]  event_code;

  controller_event_gen #(
    .POLL_PERIOD    (PP),
    .PULSE_CYCLES   (PC),
    .SCAN_WAIT      (SW),
    .DEBOUNCE_POLLS (DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .buttons_in     (buttons_in),
    .poll_req       (poll_req),
    .buttons_stable (buttons_stable),
    .event_valid    (event_valid),
    .event_code     (event_code),
    .event_ack      (event_ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] hist[$];
  logic [10:0] m_stable;
  logic [10:0] m_pending;
  bit          m_valid;
  logic [3:0]  m_code;
  int          held[4];
  int          off;
  bit          last_pr;
  int          prev_start;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  endtask

  task automatic step();
    @(negedge clock);
    off++;
  endtask

  function automatic logic [3:0] highest(input logic [10:0] m);
    for (int i = 10; i >= 0; i--) if (m[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_stable  = '0;
    m_pending = '0;
    m_valid   = 1'b0;
    m_code    = '0;
    for (int d = 0; d < 4; d++) held[d] = -1;
  endtask

  // One poll: accept a word after DB identical samples in a row,
  // presses are new stable bits, held directions repeat at RD, RD+RR...
  task automatic model_update(input logic [10:0] s);
    int run;
    logic [10:0] old;
    logic [10:0] setm;
    hist.push_back(s);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] !== s) break;
      run++;
    end
    old = m_stable;
    if (run >= DB) m_stable = s;
    setm = m_stable & ~old;
    for (int d = 0; d < 4; d++) begin
      if (!m_stable[7+d]) held[d] = -1;
      else if (setm[7+d]) held[d] = 0;
      else begin
        held[d]++;
        if (held[d] >= RD && (held[d] - RD) % RR == 0)
          setm[7+d] = 1'b1;
      end
    end
    m_pending |= setm;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    event_ack = 1'b0;
    buttons_in = '0;
    #1;
    chk("rst_poll_req", poll_req, 0);
    chk("rst_valid", event_valid, 0);
    chk("rst_code", event_code, 0);
    chk("rst_stable", buttons_stable, 0);
    repeat (3) @(negedge clock);
    model_reset();
    last_pr = 1'b0;
    prev_start = -1;
    reset = 1'b1;
  endtask

  task automatic wait_start();
    int n;
    bit pr;
    n = 0;
    forever begin
      @(negedge clock);
      pr = poll_req;
      if (pr && !last_pr) begin
        last_pr = pr;
        break;
      end
      last_pr = pr;
      n++;
      if (n > 400) begin
        n_cmp++;
        n_bad++;
        $display("FAIL poll_start: observed no rising poll_req, required one within 400 cycles");
        finish_up();
      end
    end
    off = 0;
    if (prev_start >= 0) chk("poll_period", cyc - prev_start, PP);
    prev_start = cyc;
  endtask

  task automatic run_poll(input logic [11:0] smp, input bit ack,
                          input bit drop_en, output int n_ev);
    int waitn;
    int dly;
    bit hold;
    n_ev = 0;
    wait_start();
    buttons_in = smp;
    step();
    chk("pulse_hi", poll_req, 1);
    step();
    chk("pulse_lo", poll_req, 0);
    if (drop_en) enable = 1'b0;
    while (off < PC + SW + 2) step();
    model_update(smp[10:0]);
    chk("stable", buttons_stable, {1'b0, m_stable});
    if (!m_valid && m_pending != 0) begin
      m_valid = 1'b1;
      m_code = highest(m_pending);
    end
    if (ack) begin
      while (m_pending != 0) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_code = highest(m_pending);
        end
        waitn = 0;
        while (event_valid !== 1'b1 && waitn < 6) begin
          step();
          waitn++;
        end
        chk("evt_valid", event_valid, 1);
        chk("evt_code", event_code, m_code);
        dly = $urandom_range(0, 2);
        repeat (dly) step();
        if (dly > 0) chk("code_hold", event_code, m_code);
        hold = 1'($urandom_range(0, 1));
        event_ack = 1'b1;
        step();
        chk("ack_drop", event_valid, 0);
        if (hold) step();
        event_ack = 1'b0;
        m_pending[m_code] = 1'b0;
        m_valid = 1'b0;
        n_ev++;
      end
    end else begin
      while (off < 30) step();
      chk("hold_valid", event_valid, m_valid);
      if (m_valid) chk("hold_code", event_code, m_code);
    end
    while (off < 95) step();
    chk("end_valid", event_valid, m_valid);
  endtask

  initial begin
    int ne;
    int cnt;
    int pick;
    logic [11:0] cur;
    logic [11:0] rnd;
    int exp_up[9] = '{0, 1, 0, 0, 1, 0, 1, 0, 1};

    enable = 1'b1;
    model_reset();

    do_reset();
    repeat (2) run_poll(12'h000, 1'b1, 1'b0, ne);

    do_reset();
    for (int p = 1; p <= 4; p++) begin
      run_poll(12'h040, 1'b1, 1'b0, ne);
      chk("a_events", ne, (p == 2) ? 1 : 0);
    end

    do_reset();
    run_poll(12'h001, 1'b1, 1'b0, ne);
    run_poll(12'h000, 1'b1, 1'b0, ne);
    chk("glitch_events", ne, 0);
    run_poll(12'h000, 1'b1, 1'b0, ne);

    do_reset();
    for (int p = 1; p <= 9; p++) run_poll(12'h400, 1'b0, 1'b0, ne);
    run_poll(12'h400, 1'b1, 1'b0, ne);
    chk("merge_events", ne, 1);

    do_reset();
    for (int p = 0; p < 9; p++) begin
      run_poll(12'h400, 1'b1, 1'b0, ne);
      chk("up_repeat", ne, exp_up[p]);
    end

    do_reset();
    run_poll(12'h441, 1'b1, 1'b0, ne);
    run_poll(12'h441, 1'b1, 1'b0, ne);
    chk("multi_events", ne, 3);

    do_reset();
    run_poll(12'h040, 1'b0, 1'b0, ne);
    run_poll(12'h040, 1'b0, 1'b0, ne);
    wait_start();
    repeat (10) step();
    reset = 1'b0;
    #1;
    chk("mid_rst_poll", poll_req, 0);
    chk("mid_rst_valid", event_valid, 0);
    chk("mid_rst_code", event_code, 0);
    chk("mid_rst_stable", buttons_stable, 0);
    repeat (2) @(negedge clock);
    model_reset();
    last_pr = 1'b0;
    prev_start = -1;
    reset = 1'b1;
    run_poll(12'h040, 1'b1, 1'b0, ne);
    chk("post_rst_none", ne, 0);
    run_poll(12'h040, 1'b1, 1'b0, ne);
    chk("post_rst_press", ne, 1);

    run_poll(12'h040, 1'b1, 1'b1, ne);
    cnt = 0;
    repeat (250) begin
      @(negedge clock);
      if (poll_req) cnt++;
    end
    chk("disabled_idle", cnt, 0);
    enable = 1'b1;
    last_pr = 1'b0;
    prev_start = -1;

    cur = 12'h040;
    for (int p = 0; p < 30; p++) begin
      pick = $urandom_range(0, 3);
      rnd = 12'($urandom);
      if (pick == 2) cur = rnd;
      else if (pick == 3) cur = cur ^ (12'h1 << rnd[3:0] % 12);
      run_poll(cur, $urandom_range(0, 3) != 0, 1'b0, ne);
    end

    finish_up();
  end

endmodule

// File: doc/controller_event_gen.md
Name: controller_event_gen

Overview:
- Downstream consumer and poll scheduler for the 6-button gamepad scanner.
- Periodically pulses the scanner's poll request and samples the 12-bit button word once the scan has settled.
- Debounces the samples, detects presses and auto-repeats held directions.
- Presents one-at-a-time button events to game logic over a valid/ack handshake.

Parameters:
- POLL_PERIOD, 1000000, clock cycles between poll starts; must be ≥ PULSE_CYCLES+SCAN_WAIT+3 (elaboration assertion).
- PULSE_CYCLES, 4, cycles poll_req is held high per poll.
- SCAN_WAIT, 8100, cycles from poll_req falling to the sample point; must exceed the scanner's 8001-cycle scan.
- DEBOUNCE_POLLS, 2, consecutive identical samples required to accept a new stable word (1..15).
- REPEAT_DELAY, 25, polls a direction must be held before its first repeat.
- REPEAT_RATE, 6, polls between subsequent repeats.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  polling permitted
- buttons_in  in  12  scanner word: [10]up [9]down [8]left [7]right [6]a [5]b [4]c [3]x [2]y [1]z [0]start; [11] ignored
- poll_req  out  1  to scanner flag input
- buttons_stable  out  12  debounced word; bit 11 always 0
- event_valid  out  1  event available
- event_code  out  4  bit index of event button (0..10)
- event_ack  in  1  consumer accepts current event

Behaviour:
- Reset (async, active-low): poll FSM to IDLE; all counters 0; pending mask 0; poll_req=0, event_valid=0, event_code=0, buttons_stable=0. Reset mid-poll abandons the poll; no sample is taken.
- Poll FSM, all outputs registered:
  - IDLE: period counter 0. If enable=1, go to PULSE next cycle.
  - PULSE: poll_req=1 for exactly PULSE_CYCLES cycles, then go to WAIT.
  - WAIT: poll_req=0 for SCAN_WAIT cycles.
  - SAMPLE (1 cycle): capture buttons_in[10:0].
  - UPDATE (1 cycle): debounce, edge and repeat logic.
  - GAP: runs until the period counter reaches POLL_PERIOD-1, then goes to PULSE if enable=1, else to IDLE.
- Period counter starts at 0 on PULSE entry.
- enable falling mid-poll does not abort; the poll completes, then the FSM returns to IDLE.
- Debounce (word level), in UPDATE:
  - If sample == previous sample, match_cnt increments, saturating at 15; otherwise match_cnt=1.
  - When match_cnt ≥ DEBOUNCE_POLLS, buttons_stable ← sample.
  - Previous sample always updates.
- Press detect, in UPDATE: new_press = sample & ~buttons_stable_old, evaluated only when buttons_stable changes. Each set bit sets the pending bit.
- Auto-repeat, directions [10:7] only: one 8-bit held counter per direction.
  - Counter clears when the stable bit is 0 or on a press; increments each UPDATE while the stable bit is 1.
  - At count == REPEAT_DELAY, set pending and reload the counter to REPEAT_DELAY-REPEAT_RATE.
- Pending mask (11 bits):
  - Setting an already-pending bit merges; no duplicate events.
  - Release does not clear pending.
- Event output:
  - When event_valid=0 and pending≠0, next cycle: event_valid=1, event_code = highest set pending index (up highest priority, start lowest).
  - event_code is held stable while valid.
  - event_ack while valid: clear that pending bit; event_valid=0 next cycle. The earliest next event follows one cycle later.
  - event_ack while not valid is ignored.
  - Pending-set and ack-clear of the same bit in the same cycle: the set wins, so the bit stays pending.

Decomposition:
- Shared package holds button bit-index constants (BTN_START=0 … BTN_UP=10), BTN_COUNT=11 and the poll FSM state encoding.
- Natural sub-module: controller_event_arbiter, containing the pending mask, priority encoder and valid/ack register.

Test Plan:
Simulation parameters for all scenarios: POLL_PERIOD=100, PULSE_CYCLES=2, SCAN_WAIT=20, DEBOUNCE_POLLS=2, REPEAT_DELAY=3, REPEAT_RATE=2; poll 1 starts at cycle 0.
- Reset release with enable=1:
  - poll_req high at cycles 0-1 and low by cycle 2.
  - Next rising edge at cycle 100.
  - buttons_stable=0 and event_valid=0 throughout.
- buttons_in=0x040 (a) from before poll 1:
  - buttons_stable=0x040 after poll-2 UPDATE.
  - event_valid=1 with event_code=6; ack clears it.
  - No further events while a is held.
- Glitch: 0x001 at poll 1 only, 0x000 at poll 2 -> buttons_stable stays 0; no event.
- Up held (0x400) from poll 1, never acked until poll 10:
  - Exactly one pending event, code 10 (merge).
  - With ack after each event, code-10 events occur at polls 2, 5, 7, 9.
- Simultaneous press 0x441 (up, a, start) -> acked events in order 10, 6, 0, each separated by ≥1 idle cycle.
- Reset asserted during WAIT with pending=0x040 and event_valid=1 -> outputs zero immediately; after release, no event until a new debounced press.
